// File: rtl/rsa_modexp_pkg.sv
// Shared types and constants for the modular-exponentiation sequencer.
// Optional feature macro: RSA_MODEXP_EARLY_TERM_EN (see rsa_modexp_seq).
package rsa_modexp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ITER,
    S_POST,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_LOAD,
    PH_RUN,
    PH_STORE
  } phase_t;

  localparam logic [1:0] SEL1_PRE  = 2'b00;
  localparam logic [1:0] SEL1_ITER = 2'b01;
  localparam logic [1:0] SEL1_POST = 2'b10;

  // Full control word driven towards the MMM datapath
  typedef struct packed {
    logic       rst_mmm;
    logic       ld_a;
    logic       ld_r;
    logic       lock1;
    logic       lock2;
    logic [1:0] sel1;
    logic       sel2;
    logic       busy;
    logic       eoc;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{
    rst_mmm: 1'b0,
    ld_a:    1'b0,
    ld_r:    1'b0,
    lock1:   1'b0,
    lock2:   1'b0,
    sel1:    SEL1_PRE,
    sel2:    1'b0,
    busy:    1'b0,
    eoc:     1'b0
  };

endpackage

// File: rtl/rsa_op_timer.sv
// Per-operation timer: walks LOAD (1 cycle), RUN (MMM_LAT cycles),
// STORE (1 cycle), then wraps so back-to-back ops need no idle cycle.
module rsa_op_timer
  import rsa_modexp_pkg::*;
#(
  parameter int MMM_LAT = 10
) (
  input  logic   clk,
  input  logic   rstb,
  input  logic   en,
  input  logic   go,
  input  logic   clr,
  output phase_t phase,
  output logic   last
);

  localparam int CW = $clog2(MMM_LAT + 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(MMM_LAT + 1);

  logic [CW-1:0] cnt;

  // Count while an op is active; clr restarts at LOAD, en=0 freezes.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (en) begin
      if (clr) begin
        cnt <= '0;
      end else if (go) begin
        cnt <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
      end
    end
  end

  // Decode the sub-phase from the registered count.
  always_comb begin
    last  = (cnt == LAST_CNT);
    phase = PH_RUN;
    if (last) begin
      phase = PH_STORE;
    end else if (cnt == '0) begin
      phase = PH_LOAD;
    end
  end

endmodule

// File: rtl/rsa_modexp_seq.sv
// Right-to-left binary modular exponentiation sequencer driving an external
// Montgomery multiplier: PRE conversion, EXP_W square/multiply ops, POST
// conversion. Optional macro RSA_MODEXP_EARLY_TERM_EN stops iterating once
// the remaining exponent bits are all zero (no longer constant time).
//
// Handshake: start is a one-cycle request honoured only in IDLE with en=1
// and abort=0; busy is high from the cycle after acceptance until the last
// STORE; eoc pulses for exactly one cycle (DONE) when a run completes, and
// never after an abort or reset. All outputs decode from registers only.
module rsa_modexp_seq
  import rsa_modexp_pkg::*;
#(
  parameter int EXP_W   = 10,
  parameter int MMM_LAT = 10
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             start,
  input  logic             abort,
  input  logic [EXP_W-1:0] expE,
  output logic             rst_mmm,
  output logic             ld_a,
  output logic             ld_r,
  output logic             lock1,
  output logic             lock2,
  output logic [1:0]       sel1,
  output logic             sel2,
  output logic             busy,
  output logic             eoc
);

  localparam int IW = $clog2(EXP_W + 1);
  localparam logic [IW-1:0] LAST_IT = IW'(EXP_W - 1);

  state_t           state, state_n;
  logic [EXP_W-1:0] reg_exp, reg_exp_n;
  logic [IW-1:0]    it_cnt, it_cnt_n;
  phase_t           phase;
  logic             op_last;
  logic             op_active;
  logic             timer_clr;
  ctl_t             ctl;

  assign op_active = (state == S_PRE) || (state == S_ITER) || (state == S_POST);

  rsa_op_timer #(
    .MMM_LAT (MMM_LAT)
  ) u_timer (
    .clk   (clk),
    .rstb  (rstb),
    .en    (en),
    .go    (op_active),
    .clr   (timer_clr),
    .phase (phase),
    .last  (op_last)
  );

  // State, exponent shift register and iteration counter; en=0 holds all.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= S_IDLE;
      reg_exp <= '0;
      it_cnt  <= '0;
    end else if (en) begin
      state   <= state_n;
      reg_exp <= reg_exp_n;
      it_cnt  <= it_cnt_n;
    end
  end

  // Next-state logic; abort outranks every advance, including start.
  always_comb begin
    state_n   = state;
    reg_exp_n = reg_exp;
    it_cnt_n  = it_cnt;
    timer_clr = 1'b0;
    if (abort) begin
      state_n   = S_IDLE;
      timer_clr = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_n   = S_PRE;
            reg_exp_n = expE;
            it_cnt_n  = '0;
          end
        end
        S_PRE: begin
          if (op_last) begin
`ifdef RSA_MODEXP_EARLY_TERM_EN
            state_n = (reg_exp == '0) ? S_POST : S_ITER;
`else
            state_n = S_ITER;
`endif
          end
        end
        S_ITER: begin
          if (op_last) begin
            reg_exp_n = reg_exp >> 1;
            it_cnt_n  = it_cnt + IW'(1);
`ifdef RSA_MODEXP_EARLY_TERM_EN
            if ((it_cnt == LAST_IT) || (reg_exp[EXP_W-1:1] == '0)) begin
              state_n = S_POST;
            end
`else
            if (it_cnt == LAST_IT) begin
              state_n = S_POST;
            end
`endif
          end
        end
        S_POST: begin
          if (op_last) begin
            state_n = S_DONE;
          end
        end
        S_DONE: begin
          state_n = S_IDLE;
        end
        default: begin
          state_n   = S_IDLE;
          timer_clr = 1'b1;
        end
      endcase
    end
  end

  // Output decode from registered state and timer sub-phase.
  always_comb begin
    ctl = CTL_IDLE;
    case (state)
      S_PRE: begin
        ctl.sel1  = SEL1_PRE;
        ctl.sel2  = 1'b0;
        ctl.lock1 = 1'b1;
        ctl.lock2 = 1'b1;
      end
      S_ITER: begin
        ctl.sel1  = SEL1_ITER;
        ctl.sel2  = 1'b1;
        ctl.lock1 = reg_exp[0];
        ctl.lock2 = 1'b1;
      end
      S_POST: begin
        ctl.sel1  = SEL1_POST;
        ctl.sel2  = 1'b1;
        ctl.lock1 = 1'b1;
        ctl.lock2 = 1'b0;
      end
      S_DONE: begin
        ctl.eoc = 1'b1;
      end
      default: begin
        ctl = CTL_IDLE;
      end
    endcase
    if (op_active) begin
      ctl.busy = 1'b1;
      case (phase)
        PH_LOAD: begin
          ctl.ld_a    = 1'b1;
          ctl.rst_mmm = 1'b0;
        end
        PH_STORE: begin
          ctl.ld_r    = 1'b1;
          ctl.rst_mmm = 1'b1;
        end
        default: begin
          ctl.rst_mmm = 1'b1;
        end
      endcase
    end
  end

  assign rst_mmm = ctl.rst_mmm;
  assign ld_a    = ctl.ld_a;
  assign ld_r    = ctl.ld_r;
  assign lock1   = ctl.lock1;
  assign lock2   = ctl.lock2;
  assign sel1    = ctl.sel1;
  assign sel2    = ctl.sel2;
  assign busy    = ctl.busy;
  assign eoc     = ctl.eoc;

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Directed bench for rsa_modexp_seq at default parameters (EXP_W=10,
// MMM_LAT=10, op length 12 cycles). Cycle n is the interval after the
// n-th rising edge counted from the edge that samples start (edge 0).
module tb_rsa_modexp_seq;

  localparam int EXP_W = 10;
  localparam int OPL   = 12;

  logic             clk;
  logic             rstb;
  logic             en;
  logic             start;
  logic             abort;
  logic [EXP_W-1:0] expE;
  logic             rst_mmm;
  logic             ld_a;
  logic             ld_r;
  logic             lock1;
  logic             lock2;
  logic [1:0]       sel1;
  logic             sel2;
  logic             busy;
  logic             eoc;

  int tests = 0;
  int fails = 0;

  rsa_modexp_seq #(
    .EXP_W   (EXP_W),
    .MMM_LAT (10)
  ) dut (
    .clk     (clk),
    .rstb    (rstb),
    .en      (en),
    .start   (start),
    .abort   (abort),
    .expE    (expE),
    .rst_mmm (rst_mmm),
    .ld_a    (ld_a),
    .ld_r    (ld_r),
    .lock1   (lock1),
    .lock2   (lock2),
    .sel1    (sel1),
    .sel2    (sel2),
    .busy    (busy),
    .eoc     (eoc)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, eoc};
  endfunction

  // Expected control word at effective cycle e of a run with k ITER ops.
  function automatic logic [9:0] model(int e, logic [EXP_W-1:0] ev, int k);
    int tot;
    int op;
    int ph;
    logic r, la, lr, l1, l2, s2, b, eo;
    logic [1:0] s1;
    tot = (k + 2) * OPL;
    {r, la, lr, l1, l2, s2, b, eo} = '0;
    s1 = 2'b00;
    if (e >= 1 && e <= tot) begin
      op = (e - 1) / OPL;
      ph = (e - 1) % OPL;
      b  = 1'b1;
      la = (ph == 0);
      r  = (ph != 0);
      lr = (ph == OPL - 1);
      if (op == 0) begin
        s1 = 2'b00; s2 = 1'b0; l1 = 1'b1; l2 = 1'b1;
      end else if (op <= k) begin
        s1 = 2'b01; s2 = 1'b1; l1 = ev[op-1]; l2 = 1'b1;
      end else begin
        s1 = 2'b10; s2 = 1'b1; l1 = 1'b1; l2 = 1'b0;
      end
    end else if (e == tot + 1) begin
      eo = 1'b1;
    end
    return {r, la, lr, l1, l2, s1, s2, b, eo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver: start a run and check every cycle up to stop_at.
  // gap_at/gap_len: en low window; re1/re2: extra start pulses;
  // abort_at: cycle in which abort is driven (0 = none).
  task automatic run_check(input string name, input logic [EXP_W-1:0] ev, input int k,
                           input int gap_at, input int gap_len, input int re1,
                           input int re2, input int abort_at, input int stop_at);
    int e;
    logic [9:0] exp_o;
    expE  = ev;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= stop_at; r++) begin
      if (gap_len > 0 && r > gap_at && r <= gap_at + gap_len) e = gap_at;
      else if (gap_len > 0 && r > gap_at + gap_len) e = r - gap_len;
      else e = r;
      if (abort_at > 0 && r > abort_at) exp_o = '0;
      else exp_o = model(e, ev, k);
      chk($sformatf("%s_c%0d", name, r), 32'(outs()), 32'(exp_o));
      if (r < stop_at) begin
        en    = !(gap_len > 0 && r >= gap_at && r < gap_at + gap_len);
        start = (r == re1) || (r == re2);
        abort = (r == abort_at);
        expE  = EXP_W'($urandom_range(0, 1023));
        tick();
      end
    end
    en    = 1'b1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rstb  = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    expE  = '0;
    @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'h0);
    tick();
    rstb = 1'b1;
    tick();
    chk("idle_outs", 32'(outs()), 32'h0);

    // Basic run: expE=0b1011, eoc at 145
    run_check("basic", 10'b0000001011, 10, 0, 0, -1, -1, 0, 148);

    // en low for 7 cycles in ITER 3 RUN: eoc moves to 152
    run_check("engap", 10'b0000001011, 10, 52, 7, -1, -1, 0, 155);

    // abort in ITER 5 RUN, then a clean run
    run_check("abort", 10'b0000001011, 10, 0, 0, -1, -1, 76, 80);
    run_check("after_abort", 10'b0000001011, 10, 0, 0, -1, -1, 0, 148);

    // abort together with start in IDLE: start dropped
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_start_idle_%0d", i), 32'(outs()), 32'h0);
      tick();
    end

    // async reset in POST, start held across the reset edge
    run_check("prereset", 10'b0000001011, 10, 0, 0, -1, -1, 0, 136);
    rstb  = 1'b0;
    start = 1'b1;
    #1;
    chk("async_reset_now", 32'(outs()), 32'h0);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post_reset_idle_%0d", i), 32'(outs()), 32'h0);
      tick();
    end

    // start re-pulsed at cycles 20 and 100: ignored
    run_check("repulse", 10'b1010011011, 10, 0, 0, 20, 100, 0, 150);

`ifdef RSA_MODEXP_EARLY_TERM_EN
    run_check("et_one", 10'b0000000001, 1, 0, 0, -1, -1, 0, 40);
    run_check("et_zero", 10'b0000000000, 0, 0, 0, -1, -1, 0, 28);
    run_check("et_top", 10'b1000000000, 10, 0, 0, -1, -1, 0, 148);
`else
    run_check("ct_one", 10'b0000000001, 10, 0, 0, -1, -1, 0, 148);
    run_check("ct_zero", 10'b0000000000, 10, 0, 0, -1, -1, 0, 148);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_seq.md
Name: rsa_modexp_seq

Overview:
- Parametrised successor to the fixed 10-bit, fixed-latency exponentiation control unit.
- Sequences a right-to-left binary modular exponentiation over an external Montgomery multiplier (MMM) datapath.
- Three op classes: pre-conversion, EXP_W square/multiply iterations, post-conversion.
- Explicit FSM plus an op timer replace the single free-running counter; adds a start/busy/eoc handshake, synchronous abort, and programmable exponent width and MMM latency.

Parameters:
- EXP_W, 10: exponent width in bits; legal range 2..64.
- MMM_LAT, 10: RUN cycles the MMM needs per operation; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rstb  in  1  asynchronous active-low reset.
- en  in  1  global enable; low freezes all state.
- start  in  1  single-cycle request, sampled in IDLE only.
- abort  in  1  synchronous cancel.
- expE  in  EXP_W  exponent, captured on accepted start.
- rst_mmm  out  1  active-low MMM accumulator clear.
- ld_a  out  1  load MMM operand registers.
- ld_r  out  1  store MMM result.
- lock1  out  1  update-enable, result register Y.
- lock2  out  1  update-enable, base register S.
- sel1  out  2  MMM operand mux: 00 pre, 01 iterate, 10 post.
- sel2  out  1  source mux: 0 external operand, 1 internal register.
- busy  out  1  operation in progress.
- eoc  out  1  end-of-computation pulse.

Behaviour:
- Reset is asynchronous on rstb low. State goes to IDLE and all outputs take their idle values: rst_mmm=0, ld_a=0, ld_r=0, lock1=0, lock2=0, sel1=00, sel2=0, busy=0, eoc=0. reg_exp and counters clear to 0.
- Outputs are decoded only from registered state. There is no combinational path from any input to any output.
- en=0: state, op timer, iteration counter and reg_exp all hold, and outputs hold. start and abort are ignored.
- States: IDLE, PRE, ITER, POST, DONE.
  - Each op state runs a LOAD/RUN/STORE sub-phase sequence taken from the op timer.
  - Op length is MMM_LAT+2 cycles: LOAD 1, RUN MMM_LAT, STORE 1.
- Sub-phase outputs:
  - LOAD: ld_a=1, rst_mmm=0.
  - RUN: ld_a=0, rst_mmm=1.
  - STORE: ld_r=1, rst_mmm=1.
- IDLE: on start=1 and en=1, capture reg_exp<=expE, clear the iteration counter, go to PRE; busy rises the next cycle.
- PRE: sel1=00, sel2=0, lock1=1, lock2=1. After STORE, go to ITER.
- ITER: sel1=01, sel2=1, lock1=reg_exp[0], lock2=1.
  - In STORE: reg_exp<=reg_exp>>1 and the iteration counter increments.
  - When the counter reaches EXP_W, go to POST; otherwise start the next ITER LOAD.
- POST: sel1=10, sel2=1, lock1=1, lock2=0. After STORE, go to DONE.
- DONE: one cycle with eoc=1, busy=0 and all other outputs at idle values; then IDLE.
- Latency: start sampled at edge 0 gives eoc high in cycle 1+(EXP_W+2)*(MMM_LAT+2). With the defaults this is cycle 145.
- start while busy: ignored; no queueing.
- abort=1 with en=1 in any non-IDLE state: the next cycle is IDLE with idle outputs, no eoc. abort has priority over state advance.
- abort and start together in IDLE: abort wins and the start is dropped.
- Async reset mid-operation behaves as abort, but takes effect immediately.
- expE changes after capture have no effect.

Optional Feature:
- Macro RSA_MODEXP_EARLY_TERM_EN.
- Defined:
  - In ITER STORE, if (reg_exp>>1)==0, go to POST immediately.
  - After PRE STORE, if reg_exp==0, skip ITER entirely.
  - Latency becomes 1+(k+2)*(MMM_LAT+2), where k is the index of the highest set bit plus 1, or 0 for a zero exponent.
- Undefined: always exactly EXP_W iterations (constant time).

Decomposition:
- Package rsa_modexp_pkg holds:
  - the state enum;
  - sub-phase enum LOAD/RUN/STORE;
  - SEL1_PRE=2'b00, SEL1_ITER=2'b01, SEL1_POST=2'b10;
  - idle output constants.
- One sub-module, rsa_op_timer:
  - counter of width $clog2(MMM_LAT+2);
  - inputs clk, rstb, en, go, clr;
  - outputs the current sub-phase and a last (STORE) flag.

Test Plan:
- Defaults, expE=10'b0000001011, start pulse → busy next cycle. lock1 in ITER ops 0..9 = 1,1,0,1,0,0,0,0,0,0. ld_r pulses at cycles 12,24,...,144. eoc single pulse at cycle 145.
- Same run with en low for 7 cycles during the ITER 3 RUN sub-phase → all outputs frozen during the gap; eoc at cycle 152.
- abort asserted in ITER 5 RUN → next cycle busy=0, idle outputs, no eoc. A new start then completes normally at +145.
- rstb low during POST → immediate idle outputs. A start asserted together with rstb deasserting that cycle is ignored.
- start re-pulsed at cycles 20 and 100 during a run → no effect; exactly one eoc at cycle 145.
- Macro defined, expE=1 → one ITER op, eoc at cycle 37. expE=0 → PRE then POST, eoc at cycle 25.
